// File: rtl/memory_arbiter.sv
// Arbitrates the instruction-fetch and load/store ports onto the single memory port.
// Each access is sequenced IDLE -> ACCESS -> DONE, and illegal accesses skip ACCESS.
module memory_arbiter #(
    parameter bit ROUND_ROBIN = 1'b1,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic                  i_ack,
    output logic [31:0]           i_rdata,
    output logic                  i_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [2:0]            d_option,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [31:0]           d_wdata,
    output logic                  d_ack,
    output logic [31:0]           d_rdata,
    output logic                  d_err,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [2:0]            mem_option,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic                  busy
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;
    localparam logic       PORT_D    = 1'b0;
    localparam logic       PORT_I    = 1'b1;
    localparam logic [2:0] OPT_WORD  = 3'b010;

    logic [1:0]            state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  port_q, port_d;
    logic                  we_q, we_d;
    logic [2:0]            opt_q, opt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  grant_any, grant_i;
    logic                  sel_we, sel_illegal;
    logic [2:0]            sel_opt;
    logic [ADDR_WIDTH-1:0] sel_addr;

    // On a tie the round-robin build hands the grant to whoever did not win last time.
    always_comb begin
        grant_any = i_req | d_req;
        if (i_req && d_req) grant_i = ROUND_ROBIN && (last_grant_q == PORT_D);
        else                grant_i = i_req;
        sel_we   = grant_i ? 1'b0 : d_we;
        sel_opt  = grant_i ? OPT_WORD : d_option;
        sel_addr = grant_i ? i_address : d_address;
    end

    always_comb begin
        case (sel_opt)
            3'b011, 3'b110, 3'b111: sel_illegal = 1'b1;
            3'b001, 3'b101:         sel_illegal = sel_addr[0];
            3'b010:                 sel_illegal = |sel_addr[1:0];
            default:                sel_illegal = 1'b0;
        endcase
        if (sel_we && sel_opt[2]) sel_illegal = 1'b1;
    end

    always_comb begin
        // NOTE: every _d starts as its _q so no path leaves a variable unassigned (no latch).
        state_d      = state_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        we_d         = we_q;
        opt_d        = opt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    port_d       = grant_i ? PORT_I : PORT_D;
                    last_grant_d = grant_i ? PORT_I : PORT_D;
                    we_d         = sel_we;
                    opt_d        = sel_opt;
                    addr_d       = sel_addr;
                    wdata_d      = grant_i ? 32'h0 : d_wdata;
                    err_d        = sel_illegal;
                    rdata_d      = 32'h0;
                    state_d      = sel_illegal ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                rdata_d = we_q ? 32'h0 : mem_rdata;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                rdata_d = 32'h0;
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= PORT_D;
            port_q       <= PORT_D;
            we_q         <= 1'b0;
            opt_q        <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
            rdata_q      <= 32'h0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            we_q         <= we_d;
            opt_q        <= opt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    // Strobes decode straight from state so an asynchronous reset kills a pending write.
    logic in_access, in_done;
    assign in_access   = (state_q == ST_ACCESS);
    assign in_done     = (state_q == ST_DONE);
    assign mem_read    = in_access & ~we_q;
    assign mem_write   = in_access & we_q;
    assign mem_option  = in_access ? opt_q : 3'b000;
    assign mem_address = in_access ? addr_q : '0;
    assign mem_wdata   = in_access ? wdata_q : 32'h0;

    assign i_ack   = in_done & (port_q == PORT_I);
    assign i_rdata = i_ack ? rdata_q : 32'h0;
    assign i_err   = i_ack & err_q;
    assign d_ack   = in_done & (port_q == PORT_D);
    assign d_rdata = d_ack ? rdata_q : 32'h0;
    assign d_err   = d_ack & err_q;
    assign busy    = (state_q != ST_IDLE);
endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: a byte-array memory model, a reference model of legality and
// load/store results feeding per-port scoreboards, and a fixed-priority instance for ties.
module tb_memory_arbiter;
    typedef struct { logic [31:0] rdata; logic err; } resp_t;
    typedef struct { logic port; logic [31:0] rdata; } fresp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_req, i_ack, i_err, d_req, d_we, d_ack, d_err;
    logic        mem_read, mem_write, busy;
    logic [31:0] i_address, i_rdata, d_address, d_wdata, d_rdata;
    logic [31:0] mem_address, mem_wdata, mem_rdata;
    logic [2:0]  d_option, mem_option;

    logic        f_i_req, f_i_ack, f_i_err, f_d_req, f_d_we, f_d_ack, f_d_err;
    logic        f_mem_read, f_mem_write, f_busy;
    logic [31:0] f_i_address, f_i_rdata, f_d_address, f_d_wdata, f_d_rdata;
    logic [31:0] f_mem_address, f_mem_wdata, f_mem_rdata;
    logic [2:0]  f_d_option, f_mem_option;

    always #5 clk = ~clk;

    memory_arbiter #(.ROUND_ROBIN(1'b1), .ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_address(i_address), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_option(d_option), .d_address(d_address),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_option(mem_option),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    memory_arbiter #(.ROUND_ROBIN(1'b0), .ADDR_WIDTH(32)) dut_fp (
        .clk(clk), .reset(reset),
        .i_req(f_i_req), .i_address(f_i_address), .i_ack(f_i_ack), .i_rdata(f_i_rdata),
        .i_err(f_i_err), .d_req(f_d_req), .d_we(f_d_we), .d_option(f_d_option),
        .d_address(f_d_address), .d_wdata(f_d_wdata), .d_ack(f_d_ack), .d_rdata(f_d_rdata),
        .d_err(f_d_err), .mem_read(f_mem_read), .mem_write(f_mem_write),
        .mem_option(f_mem_option), .mem_address(f_mem_address), .mem_wdata(f_mem_wdata),
        .mem_rdata(f_mem_rdata), .busy(f_busy)
    );

    // The fixed-priority instance sees a memory whose contents are the inverted address.
    assign f_mem_rdata = ~f_mem_address;

    // Memory device model: 1 KiB of bytes, combinational read, write on the clock edge.
    logic [7:0] ram [0:1023];
    logic [9:0] ma;
    logic       poke_en = 1'b0;
    logic [9:0] poke_addr = 10'h0;
    logic [31:0] poke_data = 32'h0;
    assign ma = mem_address[9:0];

    always_comb begin
        case (mem_option)
            3'b000:  mem_rdata = {24'h0, ram[ma]};
            3'b100:  mem_rdata = {{24{ram[ma][7]}}, ram[ma]};
            3'b001:  mem_rdata = {16'h0, ram[ma + 10'd1], ram[ma]};
            3'b101:  mem_rdata = {{16{ram[ma + 10'd1][7]}}, ram[ma + 10'd1], ram[ma]};
            default: mem_rdata = {ram[ma + 10'd3], ram[ma + 10'd2], ram[ma + 10'd1], ram[ma]};
        endcase
    end

    always @(posedge clk) begin
        if (mem_write) begin
            ram[ma] <= mem_wdata[7:0];
            if (mem_option[1:0] != 2'b00) ram[ma + 10'd1] <= mem_wdata[15:8];
            if (mem_option[1:0] == 2'b10) begin
                ram[ma + 10'd2] <= mem_wdata[23:16];
                ram[ma + 10'd3] <= mem_wdata[31:24];
            end
        end
        if (poke_en) begin
            for (int k = 0; k < 4; k++) ram[poke_addr + 10'(k)] <= 8'(poke_data >> (8 * k));
        end
    end

    // Reference model: shadow byte image plus access rules.
    logic [7:0] sh [0:1023];
    resp_t      exp_i[$];
    resp_t      exp_d[$];
    fresp_t     fexp[$];
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_size(input logic [2:0] opt);
        case (opt)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit ref_illegal(input logic we, input logic [2:0] opt, input int a);
        int n = ref_size(opt);
        if (n == 0) return 1'b1;
        if (we && opt[2]) return 1'b1;
        return (a % n) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] opt, input int a);
        int     n = ref_size(opt);
        longint v = 0;
        for (int k = 0; k < n; k++) v += longint'(sh[(a + k) % 1024]) << (8 * k);
        if (opt[2] && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [2:0] opt, input int a, input logic [31:0] wdata);
        for (int k = 0; k < ref_size(opt); k++) sh[(a + k) % 1024] = 8'(wdata >> (8 * k));
    endtask

    task automatic poke_word(input int a, input logic [31:0] v);
        for (int k = 0; k < 4; k++) sh[(a + k) % 1024] = 8'(v >> (8 * k));
        poke_addr = 10'(a);
        poke_data = v;
        poke_en   = 1'b1;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    // Scoreboard monitors: pop the expected response whenever an ack appears.
    resp_t  mon_r;
    fresp_t mon_f;
    logic   prev_strobe = 1'b0;

    always @(negedge clk) begin
        if (i_ack) begin
            if (exp_i.size() == 0) check("i_unexpected_ack", 32'(i_ack), 32'd0);
            else begin
                mon_r = exp_i.pop_front();
                check("i_rdata", i_rdata, mon_r.rdata);
                check("i_err", 32'(i_err), 32'(mon_r.err));
            end
        end
        if (d_ack) begin
            if (exp_d.size() == 0) check("d_unexpected_ack", 32'(d_ack), 32'd0);
            else begin
                mon_r = exp_d.pop_front();
                check("d_rdata", d_rdata, mon_r.rdata);
                check("d_err", 32'(d_err), 32'(mon_r.err));
            end
        end
        check("single_ack", 32'(i_ack & d_ack), 32'd0);
        check("quiet_ports", (i_ack ? 32'h0 : (i_rdata | 32'(i_err))) |
                             (d_ack ? 32'h0 : (d_rdata | 32'(d_err))), 32'd0);
        check("quiet_mem", (mem_read | mem_write) ? 32'h0 :
                           (mem_address | mem_wdata | 32'(mem_option)), 32'd0);
        check("rw_exclusive", 32'(mem_read & mem_write), 32'd0);
        check("strobe_one_cycle", 32'(prev_strobe & (mem_read | mem_write)), 32'd0);
        check("busy_when_active", 32'(!busy && (mem_read | mem_write | i_ack | d_ack)), 32'd0);
        prev_strobe <= mem_read | mem_write;
    end

    always @(negedge clk) begin
        if (f_i_ack | f_d_ack) begin
            if (fexp.size() == 0) check("fp_unexpected_ack", 32'(f_i_ack | f_d_ack), 32'd0);
            else begin
                mon_f = fexp.pop_front();
                check("fp_grant_port", 32'(f_i_ack), 32'(mon_f.port));
                check("fp_rdata", f_i_ack ? f_i_rdata : f_d_rdata, mon_f.rdata);
            end
        end
    end

    task automatic d_txn(input logic we, input logic [2:0] opt, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat, output int strobes,
                         output logic [31:0] rd, output logic er);
        resp_t r;
        bit    bad = ref_illegal(we, opt, int'(addr));
        r.err   = bad;
        r.rdata = (bad || we) ? 32'h0 : ref_load(opt, int'(addr));
        if (!bad && we) ref_store(opt, int'(addr), wdata);
        exp_d.push_back(r);
        @(posedge clk);
        #1;
        d_we = we; d_option = opt; d_address = addr; d_wdata = wdata; d_req = 1'b1;
        lat = 0; strobes = 0; rd = 32'h0; er = 1'b0;
        forever begin
            @(negedge clk);
            lat++;
            strobes += (mem_read | mem_write) ? 1 : 0;
            if (d_ack) begin rd = d_rdata; er = d_err; break; end
            if (lat >= 40) begin check("d_ack_timeout", 32'(d_ack), 32'd1); break; end
        end
        @(posedge clk);
        #1 d_req = 1'b0;
    endtask

    task automatic i_txn(input logic [31:0] addr, output int lat, output int strobes,
                         output logic [31:0] rd, output logic er);
        resp_t r;
        r.err   = ref_illegal(1'b0, 3'b010, int'(addr));
        r.rdata = r.err ? 32'h0 : ref_load(3'b010, int'(addr));
        exp_i.push_back(r);
        @(posedge clk);
        #1;
        i_address = addr; i_req = 1'b1;
        lat = 0; strobes = 0; rd = 32'h0; er = 1'b0;
        forever begin
            @(negedge clk);
            lat++;
            strobes += (mem_read | mem_write) ? 1 : 0;
            if (i_ack) begin rd = i_rdata; er = i_err; break; end
            if (lat >= 40) begin check("i_ack_timeout", 32'(i_ack), 32'd1); break; end
        end
        @(posedge clk);
        #1 i_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, strobes, guard, dcount;
        logic [31:0] rd;
        logic        er;
        resp_t       r;
        fresp_t      fr;
        int          obs[$];
        int          rr_exp[4] = '{21, 52, 81, 112};

        i_req = 1'b0; i_address = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_option = 3'b000; d_address = 32'h0; d_wdata = 32'h0;
        f_i_req = 1'b0; f_i_address = 32'h0; f_d_req = 1'b0; f_d_we = 1'b0;
        f_d_option = 3'b010; f_d_address = 32'h0; f_d_wdata = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl_outputs",
              32'({i_ack, i_err, d_ack, d_err, mem_read, mem_write, busy, f_busy}), 32'd0);
        check("reset_data_outputs",
              i_rdata | d_rdata | mem_address | mem_wdata | 32'(mem_option), 32'd0);

        for (int w = 0; w < 256; w++) poke_word(w * 4, $urandom);
        poke_word(32'h20, 32'h8000_00F0);

        // Both ports requesting out of reset: I wins first, then strict alternation.
        i_address = 32'h0; i_req = 1'b1;
        d_we = 1'b0; d_option = 3'b010; d_address = 32'h104; d_req = 1'b1;
        r.err = 1'b0;
        r.rdata = ref_load(3'b010, 0);
        exp_i.push_back(r); exp_i.push_back(r);
        r.rdata = ref_load(3'b010, 32'h104);
        exp_d.push_back(r); exp_d.push_back(r);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (i_ack | d_ack) obs.push_back((k + 1) * 10 + (i_ack ? 1 : 2));
        end
        @(posedge clk);
        #1 i_req = 1'b0; d_req = 1'b0;
        check("rr_ack_count", obs.size(), 4);
        for (int n = 0; n < 4; n++) check("rr_ack_slot", (n < obs.size()) ? obs[n] : -1, rr_exp[n]);
        repeat (3) @(posedge clk);

        d_txn(1'b0, 3'b100, 32'h20, 32'h0, lat, strobes, rd, er);
        check("lb_latency", lat, 3);
        check("lb_strobes", strobes, 1);
        check("lb_sign_extended", rd, 32'hFFFF_FFF0);

        d_txn(1'b1, 3'b010, 32'h40, 32'h1234_5678, lat, strobes, rd, er);
        check("sw_latency", lat, 3);
        check("sw_strobes", strobes, 1);
        check("sw_rdata_zero", rd, 32'h0);
        i_txn(32'h40, lat, strobes, rd, er);
        check("fetch_latency", lat, 3);
        check("fetch_after_store", rd, 32'h1234_5678);
        check("fetch_err", 32'(er), 32'd0);

        d_txn(1'b0, 3'b010, 32'h42, 32'h0, lat, strobes, rd, er);
        check("lw_misaligned_latency", lat, 2);
        check("lw_misaligned_strobes", strobes, 0);
        check("lw_misaligned_err", 32'(er), 32'd1);
        d_txn(1'b1, 3'b101, 32'h44, 32'hFFFF_FFFF, lat, strobes, rd, er);
        check("signed_store_err", 32'(er), 32'd1);
        check("signed_store_strobes", strobes, 0);
        i_txn(32'h6, lat, strobes, rd, er);
        check("fetch_misaligned_err", 32'(er), 32'd1);
        check("fetch_misaligned_latency", lat, 2);

        // Reset in the middle of a store: the strobe must vanish and memory stay intact.
        poke_word(32'h10, 32'h0BAD_F00D);
        @(posedge clk);
        #1;
        d_we = 1'b1; d_option = 3'b010; d_address = 32'h10; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!mem_write && guard < 10);
        check("rst_store_reached_access", 32'(mem_write), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("rst_drops_mem_write", 32'(mem_write), 32'd0);
        check("rst_clears_busy", 32'(busy), 32'd0);
        check("rst_no_ack", 32'(d_ack), 32'd0);
        d_req = 1'b0; d_we = 1'b0; d_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        check("rst_store_not_written", {ram[10'h13], ram[10'h12], ram[10'h11], ram[10'h10]},
              32'h0BAD_F00D);

        // Fixed priority: D keeps winning while it requests; I only after D lets go.
        for (int n = 0; n < 3; n++) begin
            fr.port = 1'b0; fr.rdata = ~32'h0C; fexp.push_back(fr);
        end
        fr.port = 1'b1; fr.rdata = ~32'h08; fexp.push_back(fr);
        @(posedge clk);
        #1;
        f_i_address = 32'h08; f_d_address = 32'h0C; f_d_we = 1'b0; f_d_option = 3'b010;
        f_i_req = 1'b1; f_d_req = 1'b1;
        dcount = 0; guard = 0;
        while (dcount < 3 && guard < 40) begin
            @(negedge clk);
            guard++;
            if (f_d_ack) dcount++;
        end
        check("fp_d_acks_while_held", dcount, 3);
        @(posedge clk);
        #1 f_d_req = 1'b0;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!f_i_ack && guard < 20);
        check("fp_i_ack_after_d_drop", 32'(f_i_ack), 32'd1);
        @(posedge clk);
        #1 f_i_req = 1'b0;

        // Random traffic: I fetches from 0x000-0x0FF, D loads/stores in 0x100-0x1FF.
        fork
            begin
                int          l, s;
                logic [31:0] a, x;
                logic        e;
                repeat (60) begin
                    a = 32'($urandom_range(0, 63)) * 4;
                    if ($urandom_range(0, 7) == 0) a += 32'($urandom_range(1, 3));
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    i_txn(a, l, s, x, e);
                end
            end
            begin
                int          l, s, sz;
                logic [31:0] a, x;
                logic [2:0]  o;
                logic        w, e;
                repeat (80) begin
                    o  = 3'($urandom_range(0, 7));
                    w  = 1'($urandom_range(0, 1));
                    a  = 32'h100 + 32'($urandom_range(0, 255));
                    sz = ref_size(o);
                    if (sz != 0 && $urandom_range(0, 3) != 0) a = a & ~(32'(sz) - 32'd1);
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    d_txn(w, o, a, $urandom, l, s, x, e);
                end
            end
        join

        repeat (6) @(posedge clk);
        check("exp_i_drained", exp_i.size(), 0);
        check("exp_d_drained", exp_d.size(), 0);
        check("fexp_drained", fexp.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
